// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter and the
// downstream digit-select mux.
package bin_to_bcd_seq_pkg;

    // FSM state encodings (kept as plain constants for legacy compatibility)
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // One BCD digit is four bits; three digits cover values up to 511
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned BCD_W      = DIGIT_W * NUM_DIGITS;

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    // Add 3 to digits >= 5; the sum stays within four bits for BCD inputs
    always_comb begin
        dout = din;
        if (din >= DIGIT_W'(5)) begin
            dout = din + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// A start/busy/done handshake launches a conversion; the registered digit
// outputs change only on the edge that raises done.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   bin,
    output logic               busy,
    output logic               done,
    output logic [DIGIT_W-1:0] ones,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] hundreds
);

    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 4 || WIDTH > 9) begin : g_bad_width
        $error("bin_to_bcd_seq: WIDTH must be in 4..9");
    end

    logic [0:0]       state;
    logic [WIDTH-1:0] bin_sr;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] bcd_nxt;
    logic [WIDTH-1:0] sr_nxt;
    logic [CW-1:0]    cnt;

    // Inputs never exceed 511, so the top bit of the corrected hundreds
    // digit is always zero and is dropped by the shift.
    logic unused_top;
    assign unused_top = adj[BCD_W-1];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_add3 u_add3 (
            .din  (bcd[g*DIGIT_W +: DIGIT_W]),
            .dout (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // One double-dabble iteration: corrected digits and binary shift left as one word
    always_comb begin
        bcd_nxt = {adj[BCD_W-2:0], bin_sr[WIDTH-1]};
        sr_nxt  = {bin_sr[WIDTH-2:0], 1'b0};
    end

    // Handshake FSM, bit counter, working registers and registered digits
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ones     <= '0;
            tens     <= '0;
            hundreds <= '0;
            bin_sr   <= '0;
            bcd      <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_sr <= bin;
                        bcd    <= '0;
                        cnt    <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bin_sr <= sr_nxt;
                    bcd    <= bcd_nxt;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        ones     <= bcd_nxt[0*DIGIT_W +: DIGIT_W];
                        tens     <= bcd_nxt[1*DIGIT_W +: DIGIT_W];
                        hundreds <= bcd_nxt[2*DIGIT_W +: DIGIT_W];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (WIDTH=8 and WIDTH=9 builds).
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, start9;
    logic [7:0] bin8;
    logic [8:0] bin9;
    logic       busy8, done8, busy9, done9;
    logic [3:0] ones8, tens8, hund8, ones9, tens9, hund9;

    logic [11:0] res8, res9;
    assign res8 = {hund8, tens8, ones8};
    assign res9 = {hund9, tens9, ones9};

    bin_to_bcd_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .bin(bin8),
        .busy(busy8), .done(done8), .ones(ones8), .tens(tens8), .hundreds(hund8)
    );

    bin_to_bcd_seq #(.WIDTH(9)) dut9 (
        .clk(clk), .rst(rst), .start(start9), .bin(bin9),
        .busy(busy9), .done(done9), .ones(ones9), .tens(tens9), .hundreds(hund9)
    );

    typedef struct packed {
        logic [8:0]  v;
        logic [11:0] exp;   // expected hundreds/tens/ones as hex nibbles
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Launch one conversion, return result and cycles from acceptance to done
    task automatic convert(input int sel, input logic [8:0] v,
                           output logic [11:0] res, output int lat);
        @(negedge clk);
        if (sel == 8) begin start8 = 1'b1; bin8 = v[7:0]; end
        else          begin start9 = 1'b1; bin9 = v;      end
        @(negedge clk);
        start8 = 1'b0;
        start9 = 1'b0;
        lat = 0;
        while (((sel == 8) ? done8 : done9) !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = (sel == 8) ? res8 : res9;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        t8[13];
        vec_t        t9[5];
        logic [11:0] r;
        int          lat;
        int          ndone, bad, bbad;

        t8 = '{ '{9'd0,   12'h000}, '{9'd255, 12'h255}, '{9'd100, 12'h100},
                '{9'd99,  12'h099}, '{9'd128, 12'h128}, '{9'd200, 12'h200},
                '{9'd42,  12'h042}, '{9'd1,   12'h001}, '{9'd9,   12'h009},
                '{9'd10,  12'h010}, '{9'd199, 12'h199}, '{9'd250, 12'h250},
                '{9'd63,  12'h063} };
        t9 = '{ '{9'd511, 12'h511}, '{9'd509, 12'h509}, '{9'd256, 12'h256},
                '{9'd300, 12'h300}, '{9'd0,   12'h000} };

        rst = 1'b1; start8 = 1'b0; start9 = 1'b0; bin8 = '0; bin9 = '0;
        repeat (3) @(negedge clk);
        check("reset busy8", {31'd0, busy8}, 32'd0);
        check("reset done8", {31'd0, done8}, 32'd0);
        check("reset digits8", {20'd0, res8}, 32'h000);
        check("reset busy9", {31'd0, busy9}, 32'd0);
        check("reset digits9", {20'd0, res9}, 32'h000);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            convert(8, t8[i].v, r, lat);
            check($sformatf("w8 digits bin=%0d", t8[i].v), {20'd0, r}, {20'd0, t8[i].exp});
            check($sformatf("w8 latency bin=%0d", t8[i].v), lat, 8);
        end
        for (int i = 0; i < 5; i++) begin
            convert(9, t9[i].v, r, lat);
            check($sformatf("w9 digits bin=%0d", t9[i].v), {20'd0, r}, {20'd0, t9[i].exp});
            check($sformatf("w9 latency bin=%0d", t9[i].v), lat, 9);
        end

        // Outputs hold previous result until the next done edge
        convert(8, 9'd255, r, lat);
        @(negedge clk); start8 = 1'b1; bin8 = 8'd100;
        @(negedge clk); start8 = 1'b0;
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8 && (res8 !== 12'h255 || done8 !== 1'b0)) bad++;
        end
        check("hold no flicker", bad, 0);
        check("hold done", {31'd0, done8}, 32'd1);
        check("hold new digits", {20'd0, res8}, 32'h100);

        // start re-asserted while busy is ignored, bin changes have no effect
        @(negedge clk); start8 = 1'b1; bin8 = 8'd99;
        @(negedge clk); start8 = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 3 || i == 5) begin start8 = 1'b1; bin8 = 8'd7; end
            else start8 = 1'b0;
            if (done8 === 1'b1) ndone++;
        end
        check("busy start ignored done count", ndone, 1);
        check("busy start ignored digits", {20'd0, res8}, 32'h099);

        // start held high: done every WIDTH+1 cycles, busy low only with done
        @(negedge clk); start8 = 1'b1; bin8 = 8'd128;
        @(negedge clk);
        ndone = 0; bad = 0; bbad = 0;
        for (int i = 1; i <= 26; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                ndone++;
                if ((i % 9) != 8) bad++;
                check("held start digits", {20'd0, res8}, 32'h128);
            end
            if (busy8 === done8) bbad++;
        end
        start8 = 1'b0;
        check("held start done count", ndone, 3);
        check("held start done spacing", bad, 0);
        check("held start busy vs done", bbad, 0);

        // Reset mid-conversion aborts with no done pulse
        @(negedge clk); start8 = 1'b1; bin8 = 8'd200;
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("abort busy", {31'd0, busy8}, 32'd0);
        check("abort done", {31'd0, done8}, 32'd0);
        check("abort digits", {20'd0, res8}, 32'h000);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) ndone++;
        end
        check("abort no done", ndone, 0);
        convert(8, 9'd42, r, lat);
        check("after abort digits", {20'd0, r}, 32'h042);
        check("after abort latency", lat, 8);

        // rst and start together: reset wins
        @(negedge clk); rst = 1'b1; start8 = 1'b1; bin8 = 8'd55;
        @(negedge clk); rst = 1'b0; start8 = 1'b0;
        check("rst beats start busy", {31'd0, busy8}, 32'd0);
        @(negedge clk);
        check("rst beats start still idle", {31'd0, busy8}, 32'd0);
        check("rst beats start digits", {20'd0, res8}, 32'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble), one bit per clock. It sits directly upstream of the calculator's 7-segment digit-select mux: it takes the calculator's unsigned binary result and produces registered ones/tens/hundreds digits. A start/busy/done handshake lets the result path launch a conversion. The displayed digits stay stable until the next conversion completes.

Parameters:
WIDTH, 8, bit width of the binary input. Legal range 4..9, so the maximum value of 511 always fits in three BCD digits. Out-of-range values are a configuration error.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a conversion of bin; sampled only in IDLE
bin  input  WIDTH  unsigned binary value; captured on the accepting edge
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse; ones/tens/hundreds updated on the same edge
ones  output  4  BCD units digit (registered)
tens  output  4  BCD tens digit (registered)
hundreds  output  4  BCD hundreds digit (registered)

Behaviour:
- Reset (rst=1 at an edge, from any state):
  - state=IDLE; busy=0, done=0, ones=tens=hundreds=0.
  - Internal shift register and bit counter cleared.
  - Reset mid-conversion aborts the conversion with no done pulse.
- States: IDLE, SHIFT.
- IDLE:
  - done=0 unless pulsed by the previous edge.
  - On an edge with start=1: capture bin into the shift register, clear the working BCD register (12 bits), set cnt=WIDTH, busy<=1, go to SHIFT.
- SHIFT (one iteration per edge):
  - Each working digit >=5 gets +3 (4-bit, no carry-out beyond the digit).
  - Then shift {bcd, bin_sr} left by one; the binary MSB enters BCD bit 0.
  - cnt decrements.
  - On the edge where cnt goes 1->0:
    - ones/tens/hundreds <= the final corrected+shifted digits;
    - done<=1 for exactly one cycle; busy<=0; state<=IDLE.
- Latency: start sampled at edge E0; done high in the cycle after edge E_WIDTH, i.e. WIDTH cycles after acceptance (8 for the default). Throughput is one conversion per WIDTH+1 cycles.
- Width rules:
  - hundreds never exceeds 5 (WIDTH=9), or 2 (WIDTH=8).
  - All digit outputs are always valid BCD (0..9).
  - Unused upper bits of the working register are never observed.
- Boundary conditions:
  - start while busy=1 is ignored; bin changes during SHIFT have no effect.
  - start asserted in the cycle done=1 (state is IDLE) is accepted. Back-to-back conversions need no idle gap beyond that cycle.
  - start held high continuously produces repeated conversions: done every WIDTH+1 cycles.
  - bin=0 still takes the full WIDTH cycles and pulses done.
  - Outputs hold the last result between conversions; they are never updated mid-conversion (no display flicker).
  - rst and start in the same cycle: rst wins.

Decomposition:
- Shared constants/include file:
  - state encodings (IDLE=1'b0, SHIFT=1'b1);
  - BCD digit width (4);
  - digit count (3).
- The digit-mux stage uses the same digit width constant.
- One natural sub-module, bcd_add3: combinational 4-bit in, 4-bit out, adds 3 when the input is >=5. Instantiated once per digit.
- Everything else (FSM, counter, shift register) lives in bin_to_bcd_seq.

Test Plan:
- Reset then start with bin=0 -> busy high 8 cycles; done pulses once in the 8th cycle after acceptance; ones=0, tens=0, hundreds=0.
- start, bin=255 -> after done: hundreds=2, tens=5, ones=5. Then start, bin=100 -> 1,0,0; outputs hold 2,5,5 until the second done edge.
- start, bin=99, then re-assert start with bin=7 at cycles 3 and 5 while busy -> result 0,9,9; exactly one done; the bin=7 requests are ignored.
- start held high with bin=128 -> done every 9 cycles, each result 1,2,8; busy low only in the done cycle.
- start bin=200, assert rst at cycle 4 -> no done pulse; busy=0; all digits 0. Next start with bin=42 -> 0,4,2 after 8 cycles.
- WIDTH=9 build, start bin=511 -> 5,1,1; bin=509 -> 5,0,9; done 9 cycles after acceptance.
